// File: rtl/hr_local_tx_pkg.sv
`default_nettype none
// ==========================================================================
// hr_local_tx_pkg : flit layout, lane encoding and lane FSM states for hr_local_tx
// Rev 1.0
// ==========================================================================
package hr_local_tx_pkg;

    localparam int CONTROL_W      = 16;
    localparam int FLIT_W         = 144;
    localparam int FLIT_VALID_BIT = 0;
    localparam int DEST_LSB       = 1;
    localparam int DEST_MSB       = 8;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    typedef enum logic [0:0] {
        LANE_EMPTY = 1'b0,
        LANE_OFFER = 1'b1
    } lane_state_t;

    function automatic logic flit_is_valid(input logic [FLIT_W-1:0] flit);
        return flit[FLIT_VALID_BIT];
    endfunction

endpackage
`default_nettype wire

// File: rtl/hr_tx_lane.sv
`default_nettype none
// ==========================================================================
// hr_tx_lane : one injection lane - FIFO, head presentation, ack FSM, stall
// watchdog; optional counters under HR_TX_STATS_EN.   Rev 1.0
// ==========================================================================
module hr_tx_lane
    import hr_local_tx_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int STALL_MAX = 64,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [FLIT_W-1:0]      wr_flit,
    input  logic                   ack,
    output logic [FLIT_W-1:0]      flit_out,
    output logic [$clog2(DEPTH):0] count,
    output logic                   stall,
    output logic                   ack_err
`ifdef HR_TX_STATS_EN
    ,
    output logic [31:0]            sent,
    output logic [31:0]            stall_cyc
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    lane_state_t       state;
    lane_state_t       state_next;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CNT_W-1:0]  stall_cnt;
    logic [FLIT_W-1:0] mem [DEPTH];
    logic              pop;

    // An ack only counts while a flit is actually being offered.
    assign pop   = ack && (state == LANE_OFFER);
    assign stall = (stall_cnt == CNT_W'(STALL_MAX));

    always_comb begin
        state_next = state;
        flit_out   = '0;
        case (state)
            LANE_EMPTY: begin
                if (wr_en) state_next = LANE_OFFER;
            end
            LANE_OFFER: begin
                flit_out = mem[rd_ptr];
                if (pop && (count == CW'(1)) && !wr_en) state_next = LANE_EMPTY;
            end
            default: state_next = LANE_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= LANE_EMPTY;
        else     state <= state_next;
    end

    // Storage carries no reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_flit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ack_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(pop);
            if (ack && (state == LANE_EMPTY)) ack_err <= 1'b1;
            if (pop || (state_next == LANE_EMPTY))
                stall_cnt <= '0;
            else if ((state == LANE_OFFER) && !stall)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

`ifdef HR_TX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sent      <= '0;
            stall_cyc <= '0;
        end else begin
            if (pop) sent <= sent + 32'd1;
            if ((state == LANE_OFFER) && !ack && (stall_cyc != 32'hFFFF_FFFF))
                stall_cyc <= stall_cyc + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/hr_local_tx.sv
`default_nettype none
// ==========================================================================
// hr_local_tx : two-lane core-side injection engine for an HRnode local port.
// Optional per-lane statistics with HR_TX_STATS_EN.   Rev 1.0
// ==========================================================================
module hr_local_tx
    import hr_local_tx_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int STALL_MAX = 64,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLIT_W-1:0]      in_flit,
    input  logic                   in_valid,
    input  logic                   in_lane,
    output logic                   in_ready,
    output logic [FLIT_W-1:0]      port0_local_o,
    output logic [FLIT_W-1:0]      port1_local_o,
    input  logic                   portl0_ack,
    input  logic                   portl1_ack,
    output logic [$clog2(DEPTH):0] lane0_count,
    output logic [$clog2(DEPTH):0] lane1_count,
    output logic [1:0]             stall,
    output logic [1:0]             ack_err
`ifdef HR_TX_STATS_EN
    ,
    output logic [31:0]            tx0_sent,
    output logic [31:0]            tx1_sent,
    output logic [31:0]            tx0_stall_cyc,
    output logic [31:0]            tx1_stall_cyc
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic wr0;
    logic wr1;

    // Ready depends only on registered occupancy, so a same-cycle ack never frees a slot.
    assign in_ready = (in_lane == LANE1) ? (lane1_count != CW'(DEPTH))
                                         : (lane0_count != CW'(DEPTH));
    assign wr0 = in_valid && in_ready && (in_lane == LANE0);
    assign wr1 = in_valid && in_ready && (in_lane == LANE1);

    hr_tx_lane #(
        .DEPTH     (DEPTH),
        .STALL_MAX (STALL_MAX),
        .CNT_W     (CNT_W)
    ) u_lane0 (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr0),
        .wr_flit   (in_flit),
        .ack       (portl0_ack),
        .flit_out  (port0_local_o),
        .count     (lane0_count),
        .stall     (stall[0]),
        .ack_err   (ack_err[0])
`ifdef HR_TX_STATS_EN
        ,
        .sent      (tx0_sent),
        .stall_cyc (tx0_stall_cyc)
`endif
    );

    hr_tx_lane #(
        .DEPTH     (DEPTH),
        .STALL_MAX (STALL_MAX),
        .CNT_W     (CNT_W)
    ) u_lane1 (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr1),
        .wr_flit   (in_flit),
        .ack       (portl1_ack),
        .flit_out  (port1_local_o),
        .count     (lane1_count),
        .stall     (stall[1]),
        .ack_err   (ack_err[1])
`ifdef HR_TX_STATS_EN
        ,
        .sent      (tx1_sent),
        .stall_cyc (tx1_stall_cyc)
`endif
    );

endmodule
`default_nettype wire

// File: tb/tb_hr_local_tx.sv
`default_nettype none
// ==========================================================================
// tb_hr_local_tx : directed scenarios plus random traffic against a queue model.
// Rev 1.0
// ==========================================================================
module tb_hr_local_tx;

    localparam int FW        = 144;
    localparam int DEPTH     = 4;
    localparam int STALL_MAX = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] in_flit;
    logic          in_valid;
    logic          in_lane;
    logic          in_ready;
    logic [FW-1:0] port0_local_o;
    logic [FW-1:0] port1_local_o;
    logic          portl0_ack;
    logic          portl1_ack;
    logic [2:0]    lane0_count;
    logic [2:0]    lane1_count;
    logic [1:0]    stall;
    logic [1:0]    ack_err;
`ifdef HR_TX_STATS_EN
    logic [31:0]   tx0_sent, tx1_sent, tx0_stall_cyc, tx1_stall_cyc;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [FW-1:0] q0[$];
    logic [FW-1:0] q1[$];
    logic [1:0]    m_err;
    int            m_wait0, m_wait1;
    longint        m_sent0, m_sent1, m_scyc0, m_scyc1;

    always #5 clk = ~clk;

    hr_local_tx #(.DEPTH(DEPTH), .STALL_MAX(STALL_MAX), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_flit       (in_flit),
        .in_valid      (in_valid),
        .in_lane       (in_lane),
        .in_ready      (in_ready),
        .port0_local_o (port0_local_o),
        .port1_local_o (port1_local_o),
        .portl0_ack    (portl0_ack),
        .portl1_ack    (portl1_ack),
        .lane0_count   (lane0_count),
        .lane1_count   (lane1_count),
        .stall         (stall),
        .ack_err       (ack_err)
`ifdef HR_TX_STATS_EN
        ,
        .tx0_sent      (tx0_sent),
        .tx1_sent      (tx1_sent),
        .tx0_stall_cyc (tx0_stall_cyc),
        .tx1_stall_cyc (tx1_stall_cyc)
`endif
    );

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_err   = 2'b00;
        m_wait0 = 0;
        m_wait1 = 0;
        m_sent0 = 0; m_sent1 = 0; m_scyc0 = 0; m_scyc1 = 0;
    endtask

    task automatic check_outputs();
        logic [FW-1:0] e0, e1;
        e0 = (q0.size() > 0) ? q0[0] : '0;
        e1 = (q1.size() > 0) ? q1[0] : '0;
        check("port0", port0_local_o, e0);
        check("port1", port1_local_o, e1);
        check("lane0_count", FW'(lane0_count), FW'(q0.size()));
        check("lane1_count", FW'(lane1_count), FW'(q1.size()));
        check("stall", FW'(stall), FW'({m_wait1 == STALL_MAX, m_wait0 == STALL_MAX}));
        check("ack_err", FW'(ack_err), FW'(m_err));
`ifdef HR_TX_STATS_EN
        check("tx0_sent", FW'(tx0_sent), FW'(m_sent0 % 64'h1_0000_0000));
        check("tx1_sent", FW'(tx1_sent), FW'(m_sent1 % 64'h1_0000_0000));
        check("tx0_stall_cyc", FW'(tx0_stall_cyc), FW'((m_scyc0 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_scyc0));
        check("tx1_stall_cyc", FW'(tx1_stall_cyc), FW'((m_scyc1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_scyc1));
`endif
    endtask

    // One clock: drive, check ready, advance model by the lane rules, check outputs.
    task automatic cycle(input logic v, input logic ln, input logic [FW-1:0] f,
                         input logic a0, input logic a1, input logic r);
        logic rdy, off0, off1, acc0, acc1;
        in_valid = v; in_lane = ln; in_flit = f;
        portl0_ack = a0; portl1_ack = a1; rst = r;
        #1;
        rdy = ln ? (q1.size() != DEPTH) : (q0.size() != DEPTH);
        check("in_ready", FW'(in_ready), FW'(rdy));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            off0 = q0.size() > 0;
            off1 = q1.size() > 0;
            acc0 = a0 && off0;
            acc1 = a1 && off1;
            if (a0 && !off0) m_err[0] = 1'b1;
            if (a1 && !off1) m_err[1] = 1'b1;
            if (acc0) begin void'(q0.pop_front()); m_sent0++; end
            if (acc1) begin void'(q1.pop_front()); m_sent1++; end
            if (off0 && !a0) m_scyc0++;
            if (off1 && !a1) m_scyc1++;
            if (v && rdy && !ln) q0.push_back(f);
            if (v && rdy &&  ln) q1.push_back(f);
            if (acc0 || q0.size() == 0) m_wait0 = 0;
            else if (off0 && m_wait0 < STALL_MAX) m_wait0++;
            if (acc1 || q1.size() == 0) m_wait1 = 0;
            else if (off1 && m_wait1 < STALL_MAX) m_wait1++;
        end
        #1;
        check_outputs();
    endtask

    function automatic logic [FW-1:0] rand_flit();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[FW-1:0];
    endfunction

    localparam logic [FW-1:0] F1 = 144'h0123456789abcdef0123456789abcdef1851;

    initial begin
        logic [FW-1:0] nf;
        in_valid = 0; in_lane = 0; in_flit = '0; portl0_ack = 0; portl1_ack = 0; rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cycle(0, 0, '0, 0, 0, 1);

        // 1: single flit on lane 0, held stable, then acked
        cycle(1, 0, F1, 0, 0, 0);
        check("t1_port0", port0_local_o, F1);
        repeat (10) cycle(0, 0, '0, 0, 0, 0);
        check("t1_hold", port0_local_o, F1);
        cycle(0, 0, '0, 1, 0, 0);
        check("t1_drain", port0_local_o, '0);

        // 2: fill lane 1, write+ack while full is refused, FIFO order
        for (int i = 1; i <= 4; i++) cycle(1, 1, F1 + FW'(i), 0, 0, 0);
        cycle(0, 0, '0, 0, 0, 0);
        check("t2_ready_l0", FW'(in_ready), FW'(1));
        cycle(1, 1, F1 + FW'(9), 0, 1, 0);
        check("t2_refused_cnt", FW'(lane1_count), FW'(3));
        check("t2_head", port1_local_o, F1 + FW'(2));
        repeat (3) cycle(0, 0, '0, 0, 1, 0);

        // 3: simultaneous acks with a same-cycle write to lane 0
        cycle(1, 0, F1 + FW'(16), 0, 0, 0);
        cycle(1, 1, F1 + FW'(17), 0, 0, 0);
        cycle(1, 0, F1 + FW'(18), 1, 1, 0);
        check("t3_port0", port0_local_o, F1 + FW'(18));
        check("t3_cnt0", FW'(lane0_count), FW'(1));
        check("t3_port1", port1_local_o, '0);

        // 4: stall watchdog
        repeat (STALL_MAX) cycle(0, 0, '0, 0, 0, 0);
        check("t4_stall", FW'(stall[0]), FW'(1));
        cycle(0, 0, '0, 0, 0, 0);
        cycle(0, 0, '0, 1, 0, 0);
        check("t4_clear", FW'(stall[0]), FW'(0));

        // 5: ack on empty lane 1 is sticky
        cycle(0, 0, '0, 0, 1, 0);
        check("t5_err", FW'(ack_err[1]), FW'(1));
        repeat (3) cycle(0, 0, '0, 0, 0, 0);
        check("t5_sticky", FW'(ack_err[1]), FW'(1));

        // 6: reset with queued flits, then ack on empty lane 0
        for (int i = 0; i < 3; i++) cycle(1, 0, rand_flit(), 0, 0, 0);
        cycle(1, 0, rand_flit(), 1, 1, 1);
        check("t6_cnt0", FW'(lane0_count), FW'(0));
        check("t6_err", FW'(ack_err), FW'(0));
        cycle(0, 0, '0, 1, 0, 0);
        check("t6_err0", FW'(ack_err[0]), FW'(1));

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            nf = rand_flit();
            cycle(($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)), nf,
                  ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 35),
                  ($urandom_range(0, 499) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
